ps2_rx_deserializer: RTL
========================

Name: ps2_rx_deserializer

Overview:
- Receive-side PS/2 host engine: synchronises and glitch-filters the raw PS/2 clock and data pins, then deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop).
- Emits one single-cycle result per frame on the ps2_rx_data__* bundle, which feeds the APB PS/2 target's FIFO directly upstream of it.
- Can inhibit the device by pulling the clock low.

Parameters:
- FILTER_LEN, 2: consecutive agreeing sample ticks required before the filtered clock/data changes.
- TIMEOUT_TICKS, 40: sample ticks without a falling clock edge mid-frame before a timeout is reported (≈120us at 3us ticks).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- divider  in  16  sample-tick divider; tick period = divider+1 clk cycles (nominally 3us)
- rx_inhibit  in  1  1 = hold PS/2 clock low, abort any frame
- ps2_in__clk  in  1  raw PS/2 clock pin (asynchronous)
- ps2_in__data  in  1  raw PS/2 data pin (asynchronous)
- ps2_out__clk  out  1  1 = float high, 0 = pull low
- ps2_out__data  out  1  1 = float high, 0 = pull low
- ps2_rx_data__valid  out  1  one-cycle pulse, frame result present
- ps2_rx_data__data  out  8  received byte
- ps2_rx_data__parity_error  out  1  qualified by valid
- ps2_rx_data__protocol_error  out  1  qualified by valid
- ps2_rx_data__timeout  out  1  qualified by valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: all ps2_rx_data__* outputs 0; ps2_out__clk and ps2_out__data 1; FSM IDLE; divider counter 0; filtered clk and data 1.
- Reset mid-frame: the partial frame is discarded with no valid pulse.
- Synchronisers: both pins pass through 2-flop synchronisers, with no reset dependence on pin values.
- Tick counter:
  - Counts 0..divider; tick asserts when count==divider, then the counter returns to 0.
  - divider=0 gives a tick every cycle.
  - A divider change takes effect at the next compare; a count already past the new value runs on and wraps at 16 bits.
- Glitch filter, evaluated on ticks only: the filtered value takes the synchronised value after FILTER_LEN consecutive ticks that differ from the current filtered value. A disagreeing tick restarts the run.
- Falling edge: filtered clk goes 1->0 on a tick. The data bit sampled is filtered data on that same tick.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0, clear the shift register and bit count, go to DATA. On a falling edge with data=1, pulse valid with protocol_error=1 and stay IDLE.
  - DATA: each edge shifts the bit in at bit7, shifting right so the byte ends LSB-first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: on the edge, pulse valid and return to IDLE.
    - data = the assembled byte.
    - parity_error = (XOR of 8 data bits and parity bit) == 0 (odd parity).
    - protocol_error = (stop bit == 0).
    - Both errors may be set together; data is always presented.
- Latency: valid is registered and appears the cycle after the tick on which the stop-bit edge is detected.
- Timeout:
  - In DATA, PARITY or STOP, a tick counter is cleared on each falling edge.
  - When it reaches TIMEOUT_TICKS: pulse valid with timeout=1, data=0, other errors 0, go IDLE.
  - Saturates; never counts in IDLE.
- Inhibit:
  - While rx_inhibit=1, ps2_out__clk=0 combinationally from a register (asserted the cycle after rx_inhibit rises).
  - The FSM is forced to IDLE with no valid pulse; the timeout count is cleared.
  - Edges seen during inhibit are ignored.
- ps2_out__data is constant 1 (receive-only block).
- Valid is a single cycle and at most one pulse per tick. Error flags are 0 whenever valid=0.

Decomposition:
- Shared ps2 package: t_ps2_pins struct (clk, data) and t_ps2_rx_data struct (valid, data, parity_error, protocol_error, timeout). These are the same types the APB target consumes.
- Local FSM state enum.
- One natural sub-module: ps2_pin_filter, covering the synchroniser plus the FILTER_LEN tick filter. It is instantiated twice, once for clk and once for data.

Test Plan:
- divider=2, frame for byte 0x1C (bits start0, 0,0,1,1,1,0,0,0, parity 0, stop1), clock half-period 10 ticks -> one valid pulse, data=0x1C, all errors 0.
- Same frame with parity bit 1 -> valid, data=0x1C, parity_error=1; stop bit 0 also -> protocol_error=1 as well.
- Clock stopped after 4 data bits, divider=2, TIMEOUT_TICKS=40 -> valid with timeout=1, data=0x00, exactly 40 ticks (120 cycles, ±3) after the last edge; the next good frame decodes correctly.
- A 1-tick low glitch on ps2_in__clk in IDLE with FILTER_LEN=2 -> no state change, no valid; a 2-tick low with data=1 -> protocol_error pulse.
- rx_inhibit raised after bit 3 -> ps2_out__clk=0 next cycle, no valid; after release, a full 0xF0 frame -> valid, data=0xF0.
- reset asserted for 1 cycle mid-frame -> all outputs at reset values next cycle; the remaining bits cause no valid until the next start bit.

Source files
------------

// File: rtl/ps2_rx_deserializer_pkg.sv
// Shared PS/2 types: pin pair, receive-result bundle and the result builder.
package ps2_rx_deserializer_pkg;

    typedef struct packed {
        logic clk;
        logic data;
    } t_ps2_pins;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       parity_error;
        logic       protocol_error;
        logic       timeout;
    } t_ps2_rx_data;

    function automatic t_ps2_rx_data make_result(
        input logic       valid,
        input logic [7:0] data,
        input logic       parity_error,
        input logic       protocol_error,
        input logic       timeout
    );
        t_ps2_rx_data r;
        r.valid          = valid;
        r.data           = data;
        r.parity_error   = parity_error;
        r.protocol_error = protocol_error;
        r.timeout        = timeout;
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_deserializer_pin_filter.sv
// Two-flop synchroniser plus tick-rate run-length glitch filter for one PS/2 pin.
module ps2_pin_filter #(
    parameter int FILTER_LEN = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pin,
    output logic filtered
);
    localparam int RUN_W = $clog2(FILTER_LEN + 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic             level_next;
    logic [RUN_W-1:0] run_reg;
    logic [RUN_W-1:0] run_next;

    // Synchroniser flops carry no reset so they always track the live pin.
    always_ff @(posedge clk) begin
        meta_reg <= pin;
        sync_reg <= meta_reg;
    end

    always_comb begin
        level_next = level_reg;
        run_next   = run_reg;
        if (tick) begin
            if (sync_reg != level_reg) begin
                if (run_reg == RUN_W'(FILTER_LEN - 1)) begin
                    level_next = sync_reg;
                    run_next   = '0;
                end else begin
                    run_next = run_reg + RUN_W'(1);
                end
            end else begin
                run_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_reg <= 1'b1;
            run_reg   <= '0;
        end else begin
            level_reg <= level_next;
            run_reg   <= run_next;
        end
    end

    // Exposes the value being adopted this cycle so edges are seen on the tick itself.
    assign filtered = level_next;

endmodule

// File: rtl/ps2_rx_deserializer.sv
// PS/2 receive engine: filtered pins, 11-bit frame deserialiser, timeout and inhibit.
module ps2_rx_deserializer
    import ps2_rx_deserializer_pkg::*;
#(
    parameter int FILTER_LEN    = 2,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divider,
    input  logic        rx_inhibit,
    input  logic        ps2_in__clk,
    input  logic        ps2_in__data,
    output logic        ps2_out__clk,
    output logic        ps2_out__data,
    output logic        ps2_rx_data__valid,
    output logic [7:0]  ps2_rx_data__data,
    output logic        ps2_rx_data__parity_error,
    output logic        ps2_rx_data__protocol_error,
    output logic        ps2_rx_data__timeout
);
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} t_rx_state;

    logic [15:0]   div_cnt_reg;
    logic          tick;
    t_ps2_pins     pins_raw;
    t_ps2_pins     pins_filt;
    logic [1:0]    raw_vec;
    logic [1:0]    filt_vec;
    logic          clk_prev_reg;
    logic          fall;
    logic          rx_bit;
    t_rx_state     state_reg;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt_reg;
    logic          parity_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic          inhibit_reg;
    t_ps2_rx_data  rx_out_reg;

    // Counter past a freshly lowered divider runs on and wraps at 16 bits.
    assign tick = (div_cnt_reg == divider);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= tick ? 16'd0 : div_cnt_reg + 16'd1;
        end
    end

    assign pins_raw.clk  = ps2_in__clk;
    assign pins_raw.data = ps2_in__data;
    assign raw_vec       = pins_raw;
    assign pins_filt     = filt_vec;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pin
            ps2_pin_filter #(
                .FILTER_LEN(FILTER_LEN)
            ) u_filter (
                .clk      (clk),
                .reset    (reset),
                .tick     (tick),
                .pin      (raw_vec[gi]),
                .filtered (filt_vec[gi])
            );
        end
    endgenerate

    assign fall   = clk_prev_reg & ~pins_filt.clk & ~inhibit_reg;
    assign rx_bit = pins_filt.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            parity_reg   <= 1'b0;
            to_cnt_reg   <= '0;
            inhibit_reg  <= 1'b0;
            clk_prev_reg <= 1'b1;
            rx_out_reg   <= '0;
        end else begin
            inhibit_reg  <= rx_inhibit;
            clk_prev_reg <= pins_filt.clk;
            rx_out_reg   <= '0;
            if (rx_inhibit) begin
                state_reg  <= ST_IDLE;
                to_cnt_reg <= '0;
            end else if (state_reg == ST_IDLE) begin
                to_cnt_reg <= '0;
                if (fall) begin
                    if (!rx_bit) begin
                        state_reg   <= ST_DATA;
                        shift_reg   <= '0;
                        bit_cnt_reg <= '0;
                    end else begin
                        rx_out_reg <= make_result(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
                    end
                end
            end else if (fall) begin
                to_cnt_reg <= '0;
                case (state_reg)
                    ST_DATA: begin
                        shift_reg   <= {rx_bit, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_reg <= rx_bit;
                        state_reg  <= ST_STOP;
                    end
                    default: begin
                        // Odd parity: the nine bits must XOR to 1.
                        rx_out_reg <= make_result(1'b1, shift_reg,
                                                  ~^{shift_reg, parity_reg},
                                                  ~rx_bit, 1'b0);
                        state_reg  <= ST_IDLE;
                    end
                endcase
            end else if (tick) begin
                if (to_cnt_reg == TO_W'(TIMEOUT_TICKS - 1)) begin
                    rx_out_reg <= make_result(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
                    state_reg  <= ST_IDLE;
                    to_cnt_reg <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + TO_W'(1);
                end
            end
        end
    end

    assign ps2_out__clk                = ~inhibit_reg;
    assign ps2_out__data               = 1'b1;
    assign ps2_rx_data__valid          = rx_out_reg.valid;
    assign ps2_rx_data__data           = rx_out_reg.data;
    assign ps2_rx_data__parity_error   = rx_out_reg.parity_error;
    assign ps2_rx_data__protocol_error = rx_out_reg.protocol_error;
    assign ps2_rx_data__timeout        = rx_out_reg.timeout;

endmodule
